// File: rtl/spi_target_pkg.sv
// spi_target_pkg: shared types and constants for the SPI mode-0 target
package spi_target_pkg;
  localparam int SPI_BYTE_W = 8;
  localparam int SPI_CNT_W = $clog2(SPI_BYTE_W);
  localparam logic [SPI_BYTE_W-1:0] SPI_IDLE_BYTE = 8'hFF;
  typedef enum logic {IDLE, SHIFT} spi_target_state_t;
endpackage

// File: rtl/spi_target_if.sv
// spi_target_if: byte-wide host port of the SPI target (slave = target side, master = host side)
interface spi_target_if;
  import spi_target_pkg::*;
  logic [SPI_BYTE_W-1:0] rx_data;
  logic rx_valid;
  logic [SPI_BYTE_W-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic busy;
  logic tx_underrun;
  modport slave (
    output rx_data, rx_valid, tx_ready, busy, tx_underrun,
    input  tx_data, tx_valid
  );
  modport master (
    input  rx_data, rx_valid, tx_ready, busy, tx_underrun,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/spi_target_sync.sv
// spi_target_sync: STAGES-deep pin synchroniser with registered level and aligned rise/fall strobes
module spi_target_sync #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= {STAGES{RST_VAL}};
      level <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[STAGES-2:0], d};
      level <= sync[STAGES-1];
      rise  <= sync[STAGES-1] & ~level;
      fall  <= ~sync[STAGES-1] & level;
    end
  end
endmodule

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target with a valid/ready byte host port.
// Define SPI_TARGET_MISO_OE_EN to add spi_miso_oe and park MISO low while deselected.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE = SPI_IDLE_BYTE
) (
  input  logic clk,
  input  logic reset,
  input  logic spi_cs,
  input  logic spi_sclk,
  input  logic spi_mosi,
  output logic spi_miso,
`ifdef SPI_TARGET_MISO_OE_EN
  output logic spi_miso_oe,
`endif
  spi_target_if.slave host
);
`ifdef SPI_TARGET_MISO_OE_EN
  localparam logic MISO_IDLE = 1'b0;
`else
  localparam logic MISO_IDLE = 1'b1;
`endif
  localparam logic [SPI_CNT_W-1:0] LAST_BIT = SPI_CNT_W'(SPI_BYTE_W - 1);
  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_rise, sclk_fall, mosi_lvl;
  logic sclk_lvl_unused, mosi_rise_unused, mosi_fall_unused;
  spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk, .reset, .d(spi_cs), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk, .reset, .d(spi_sclk), .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk, .reset, .d(spi_mosi), .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );
  spi_target_state_t state, state_nxt;
  logic [SPI_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [SPI_BYTE_W-2:0] rx_sh, rx_sh_nxt, tx_sh, tx_sh_nxt;
  logic [SPI_BYTE_W-1:0] rx_data, rx_data_nxt, hold, hold_nxt, ld_byte;
  logic miso_nxt, rx_valid, rx_valid_nxt, underrun, underrun_nxt;
  logic hold_full, hold_full_nxt, load;
  // A load samples the holding register before this cycle's host write, so a same-cycle write waits for the next load
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    rx_sh_nxt     = rx_sh;
    tx_sh_nxt     = tx_sh;
    miso_nxt      = spi_miso;
    rx_data_nxt   = rx_data;
    rx_valid_nxt  = 1'b0;
    underrun_nxt  = 1'b0;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    load          = 1'b0;
    ld_byte       = hold_full ? hold : IDLE_BYTE;
    if (cs_rise) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
      miso_nxt    = MISO_IDLE;
    end else if (state == IDLE) begin
      state_nxt = cs_fall ? SHIFT : IDLE;
      load      = cs_fall;
    end else begin
      if (sclk_rise) begin
        rx_sh_nxt    = {rx_sh[SPI_BYTE_W-3:0], mosi_lvl};
        bit_cnt_nxt  = bit_cnt + SPI_CNT_W'(1);
        rx_valid_nxt = bit_cnt == LAST_BIT;
        rx_data_nxt  = rx_valid_nxt ? {rx_sh, mosi_lvl} : rx_data;
      end
      if (sclk_fall) begin
        load      = bit_cnt == '0;
        tx_sh_nxt = load ? tx_sh : tx_sh << 1;
        miso_nxt  = load ? spi_miso : tx_sh[SPI_BYTE_W-2];
      end
    end
    if (load) begin
      tx_sh_nxt     = ld_byte[SPI_BYTE_W-2:0];
      miso_nxt      = ld_byte[SPI_BYTE_W-1];
      underrun_nxt  = !hold_full;
      hold_full_nxt = 1'b0;
    end
    if (host.tx_valid && !hold_full) begin
      hold_nxt      = host.tx_data;
      hold_full_nxt = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      spi_miso  <= MISO_IDLE;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      underrun  <= 1'b0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      rx_sh     <= rx_sh_nxt;
      tx_sh     <= tx_sh_nxt;
      spi_miso  <= miso_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= rx_valid_nxt;
      underrun  <= underrun_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
    end
  end
`ifdef SPI_TARGET_MISO_OE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) spi_miso_oe <= 1'b0;
    else spi_miso_oe <= !cs_lvl;
  end
`endif
  assign host.rx_data     = rx_data;
  assign host.rx_valid    = rx_valid;
  assign host.tx_ready    = !hold_full;
  assign host.busy        = !cs_lvl;
  assign host.tx_underrun = underrun;
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: randomized and directed bench for spi_target against an event-timed byte-level model
module tb_spi_target;
  import spi_target_pkg::*;
  localparam int S = 2;
  localparam int H = 8;
  localparam int LAT = S + 2;
`ifdef SPI_TARGET_MISO_OE_EN
  localparam logic IDLE_MISO = 1'b0;
`else
  localparam logic IDLE_MISO = 1'b1;
`endif
  localparam int CS_FALL = 0, CS_RISE = 1, SCLK_RISE = 2, SCLK_FALL = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spi_cs = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0, spi_miso;
`ifdef SPI_TARGET_MISO_OE_EN
  logic spi_miso_oe;
`endif
  spi_target_if host();
  always #5 clk = ~clk;
  spi_target #(.SYNC_STAGES(S), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .reset(reset), .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
`ifdef SPI_TARGET_MISO_OE_EN
    .spi_miso_oe(spi_miso_oe),
`endif
    .host(host)
  );
  typedef struct {int at; int kind; logic b;} ev_t;
  typedef struct {logic [7:0] d; int at;} hw_t;
  ev_t evq[$];
  hw_t hq[$];
  logic [7:0] rxq[$];
  int und_cnt, cyc, vectors, miscompares;
  bit m_sel, m_full, m_rxv, m_und;
  int m_bits;
  logic [7:0] m_rx, m_tx, m_hold, m_rxd;
  logic m_miso;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [7:0] rx_at(input int i);
    return i < rxq.size() ? rxq[i] : 8'hxx;
  endfunction
  task automatic model_init();
    evq.delete();
    hq.delete();
    m_sel = 0; m_full = 0; m_rxv = 0; m_und = 0; m_bits = 0;
    m_rx = 0; m_tx = 0; m_hold = 0; m_rxd = 0; m_miso = IDLE_MISO;
  endtask
  task automatic model_load();
    if (m_full) begin
      m_tx = m_hold;
      m_full = 0;
    end else begin
      m_tx = 8'hFF;
      m_und = 1;
    end
    m_miso = m_tx[7];
  endtask
  task automatic model_edge();
    bit wr;
    ev_t e;
    wr = host.tx_valid && !m_full;
    m_rxv = 0;
    m_und = 0;
    while (evq.size() > 0 && evq[0].at == cyc) begin
      e = evq.pop_front();
      if (e.kind == CS_FALL) begin
        m_sel = 1; m_bits = 0; model_load();
      end else if (e.kind == CS_RISE) begin
        m_sel = 0; m_bits = 0; m_miso = IDLE_MISO;
      end else if (e.kind == SCLK_RISE && m_sel) begin
        m_rx = {m_rx[6:0], e.b};
        m_bits = (m_bits + 1) % 8;
        if (m_bits == 0) begin m_rxv = 1; m_rxd = m_rx; end
      end else if (e.kind == SCLK_FALL && m_sel) begin
        if (m_bits == 0) model_load();
        else m_miso = m_tx[7 - m_bits];
      end
    end
    if (wr) begin m_hold = host.tx_data; m_full = 1; end
  endtask
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (!reset) begin
      model_edge();
      check("spi_miso", spi_miso, m_miso);
      check("tx_ready", host.tx_ready, !m_full);
      check("rx_valid", host.rx_valid, m_rxv);
      check("rx_data", host.rx_data, m_rxd);
      check("tx_underrun", host.tx_underrun, m_und);
      if (host.rx_valid) rxq.push_back(host.rx_data);
      if (host.tx_underrun) und_cnt++;
    end
    host.tx_valid = 1'b0;
    if (!reset && hq.size() > 0 && cyc >= hq[0].at - 1 && !m_full) begin
      host.tx_valid = 1'b1;
      host.tx_data = hq[0].d;
      hq.delete(0);
    end
  endtask
  task automatic wait_cycles(input int n);
    repeat (n) cycle();
  endtask
  task automatic pin(input int kind, input logic b);
    ev_t e;
    e.at = cyc + LAT; e.kind = kind; e.b = b;
    evq.push_back(e);
  endtask
  task automatic host_write(input logic [7:0] d, input int at);
    hw_t w;
    w.d = d; w.at = at;
    hq.push_back(w);
  endtask
  task automatic xfer(input logic [31:0] mo, input int nbits, output logic [31:0] mi);
    logic [31:0] sh;
    sh = mo;
    mi = 0;
    spi_cs = 1'b0;
    spi_mosi = sh[31];
    pin(CS_FALL, 1'b0);
    wait_cycles(H);
    for (int i = 0; i < nbits; i++) begin
      mi = {mi[30:0], spi_miso};
      check("busy", host.busy, 1);
      spi_sclk = 1'b1;
      pin(SCLK_RISE, spi_mosi);
      wait_cycles(H);
      sh = sh << 1;
      if (i == nbits - 1) begin
        spi_cs = 1'b1;
        pin(CS_RISE, 1'b0);
      end
      spi_sclk = 1'b0;
      spi_mosi = sh[31];
      pin(SCLK_FALL, 1'b0);
      wait_cycles(H);
    end
    wait_cycles(LAT + 2);
    check("busy idle", host.busy, 0);
  endtask
  task automatic clear_obs();
    rxq.delete();
    und_cnt = 0;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [31:0] mi;
    int t0, nbits;
    host.tx_valid = 1'b0;
    host.tx_data = 8'h00;
    vectors = 0; miscompares = 0; cyc = 0;
    model_init();
    clear_obs();
    wait_cycles(3);
    check("reset spi_miso", spi_miso, IDLE_MISO);
    check("reset rx_data", host.rx_data, 0);
    check("reset rx_valid", host.rx_valid, 0);
    check("reset tx_ready", host.tx_ready, 1);
    check("reset busy", host.busy, 0);
    check("reset tx_underrun", host.tx_underrun, 0);
    reset = 1'b0;
    wait_cycles(4);
    clear_obs();
    xfer(32'hA500_0000, 8, mi);
    check("idle miso byte", mi[7:0], 8'hFF);
    check("idle rx count", rxq.size(), 1);
    check("idle rx byte", rx_at(0), 8'hA5);
    check("idle underruns", und_cnt, 1);
    clear_obs();
    host_write(8'h3C, 0);
    wait_cycles(4);
    check("queued tx_ready low", host.tx_ready, 0);
    xfer(32'h4000_0000, 16, mi);
    check("queued miso", mi[15:0], 16'h3CFF);
    check("queued rx count", rxq.size(), 2);
    check("queued rx0", rx_at(0), 8'h40);
    check("queued rx1", rx_at(1), 8'h00);
    check("queued underruns", und_cnt, 1);
    clear_obs();
    host_write(8'h01, 0);
    host_write(8'h02, 0);
    host_write(8'h03, 0);
    wait_cycles(4);
    xfer(32'hC3A5_5A00, 24, mi);
    check("stream miso", mi[23:0], 24'h010203);
    check("stream underruns", und_cnt, 0);
    check("stream rx2", rx_at(2), 8'h5A);
    clear_obs();
    t0 = cyc;
    host_write(8'h77, t0 + LAT + 1);
    xfer(32'hFFFF_FFFF, 5, mi);
    check("abort rx count", rxq.size(), 0);
    check("abort underruns", und_cnt, 1);
    check("abort holds 77", host.tx_ready, 0);
    clear_obs();
    xfer(32'h1200_0000, 8, mi);
    check("abort resend", mi[7:0], 8'h77);
    check("abort next rx", rx_at(0), 8'h12);
    clear_obs();
    t0 = cyc;
    host_write(8'h5A, t0 + 16 * H + LAT);
    xfer(32'h0000_0000, 24, mi);
    check("simul miso", mi[23:0], 24'hFFFF5A);
    check("simul underruns", und_cnt, 2);
    spi_cs = 1'b0;
    pin(CS_FALL, 1'b0);
    wait_cycles(H);
    host_write(8'h66, 0);
    wait_cycles(4);
    spi_sclk = 1'b1;
    pin(SCLK_RISE, spi_mosi);
    wait_cycles(3);
    check("pre-reset tx_ready", host.tx_ready, 0);
    reset = 1'b1;
    #1;
    check("mid reset spi_miso", spi_miso, IDLE_MISO);
    check("mid reset tx_ready", host.tx_ready, 1);
    check("mid reset busy", host.busy, 0);
    check("mid reset rx_data", host.rx_data, 0);
    spi_cs = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    model_init();
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(4);
    clear_obs();
    xfer(32'h9600_0000, 8, mi);
    check("post reset miso", mi[7:0], 8'hFF);
    check("post reset rx", rx_at(0), 8'h96);
    for (int k = 0; k < 40; k++) begin
      nbits = $urandom_range(1, 24);
      repeat ($urandom_range(0, 2)) host_write(8'($urandom), cyc + $urandom_range(0, nbits * 2 * H + H));
      xfer($urandom, nbits, mi);
      wait_cycles($urandom_range(0, 5));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
